return_addr_stack: RTL and testbench

- Return-address stack (RAS) predictor in the fetch unit's branch predictor.
- Calls in Execute push the link PC; predicted returns in Fetch pop it.
- Mis-predicted or flushed returns repair the stack pointer.
- The top of stack drives the predicted return target in Fetch.

---
 rtl/return_addr_stack_pkg.sv | 7 +
 rtl/return_addr_stack_if.sv | 36 +++
 rtl/return_addr_stack_flopenr.sv | 15 +
 rtl/return_addr_stack_mux2.sv | 11 +
 rtl/return_addr_stack.sv | 63 ++++++
 tb/tb_return_addr_stack.sv | 148 ++++++++++++++
 6 files changed

// File: rtl/return_addr_stack_pkg.sv
// Shared core configuration for the return-address stack predictor.
// Address width and stack geometry used by every RAS file.
package return_addr_stack_pkg;
    localparam int XLEN       = 64;
    localparam int STACK_SIZE = 16;
    localparam int PTR_W      = $clog2(STACK_SIZE);
endpackage

// File: rtl/return_addr_stack_if.sv
// Pipeline control and link-address bundle seen by the RAS.
// The pipeline side is master; the RAS itself is the slave.
interface return_addr_stack_if;
    import return_addr_stack_pkg::*;

    logic            StallF;
    logic            StallD;
    logic            StallE;
    logic            StallM;
    logic            FlushD;
    logic            FlushE;
    logic            FlushM;
    logic            BPReturnWrongD;
    logic            ReturnD;
    logic            ReturnE;
    logic            CallE;
    logic            BPReturnF;
    logic [XLEN-1:0] PCLinkE;
    logic [XLEN-1:0] RASPCF;

    modport master (
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushM,
        output BPReturnWrongD, ReturnD, ReturnE,
        output CallE, BPReturnF, PCLinkE,
        input  RASPCF
    );

    modport slave (
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushM,
        input  BPReturnWrongD, ReturnD, ReturnE,
        input  CallE, BPReturnF, PCLinkE,
        output RASPCF
    );
endinterface

// File: rtl/return_addr_stack_flopenr.sv
// Enabled register with asynchronous active-low clear.
module return_addr_stack_flopenr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= '0;
        else if (en)  q <= d;
    end
endmodule

// File: rtl/return_addr_stack_mux2.sv
// Two-input selector, d1 when s is high.
module return_addr_stack_mux2 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);
    assign y = s ? d1 : d0;
endmodule

// File: rtl/return_addr_stack.sv
// Return-address stack: calls push link PCs, predicted returns pop,
// and mispredicted or flushed returns repair the pointer.
module return_addr_stack
    import return_addr_stack_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    return_addr_stack_if.slave ras
);
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] step;
    logic [XLEN-1:0]  mem [STACK_SIZE];

    logic pop_f, push_e, wrong_ret_d, flushed_ret_de;
    logic repair_d, inc_repair, dec_repair;
    logic enable, dec;
    logic unused_stall_f;

    assign unused_stall_f = ras.StallF;

    assign pop_f       = ras.BPReturnF & ~ras.StallD & ~ras.FlushD;
    assign push_e      = ras.CallE & ~ras.StallM & ~ras.FlushM;
    assign wrong_ret_d = ras.BPReturnWrongD & ~ras.StallE & ~ras.FlushE;

    assign flushed_ret_de = (~ras.StallE & ras.FlushE & ras.ReturnD)
                          | (ras.FlushM & ras.ReturnE);

    assign repair_d   = wrong_ret_d | flushed_ret_de;
    assign inc_repair = flushed_ret_de | (wrong_ret_d & ~ras.ReturnD);
    assign dec_repair = wrong_ret_d & ras.ReturnD;

    // Increment-repair wins over any pop; a push never blocks a decrement.
    assign enable = pop_f | push_e | repair_d;
    assign dec    = (pop_f | dec_repair) & ~inc_repair;

    return_addr_stack_mux2 #(.WIDTH(PTR_W)) u_step_mux (
        .d0 (PTR_W'(1)),
        .d1 ({PTR_W{1'b1}}),
        .s  (dec),
        .y  (step)
    );

    assign next_ptr = ptr + step;

    return_addr_stack_flopenr #(.WIDTH(PTR_W)) u_ptr_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (enable),
        .d       (next_ptr),
        .q       (ptr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STACK_SIZE; i++) mem[i] <= '0;
        end else if (push_e) begin
            mem[next_ptr] <= ras.PCLinkE;
        end
    end

    assign ras.RASPCF = mem[ptr];
endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack with hand-computed expectations.
module tb_return_addr_stack;
    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    return_addr_stack_if ras ();

    return_addr_stack dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ras     (ras)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ras.StallF = 0; ras.StallD = 0; ras.StallE = 0; ras.StallM = 0;
        ras.FlushD = 0; ras.FlushE = 0; ras.FlushM = 0;
        ras.BPReturnWrongD = 0; ras.ReturnD = 0; ras.ReturnE = 0;
        ras.CallE = 0; ras.BPReturnF = 0; ras.PCLinkE = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        reset_n = 0;
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    task automatic push(input logic [63:0] a);
        ras.CallE = 1; ras.PCLinkE = a;
        step();
    endtask

    task automatic check_state(input string tag, input int p,
                               input logic [63:0] top);
        chk({tag, "_ptr"}, 64'(dut.ptr), 64'(p));
        chk({tag, "_top"}, ras.RASPCF, top);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        check_state("reset", 0, 64'h0);

        push(64'h1004);
        check_state("push1", 1, 64'h1004);
        push(64'h2008);
        check_state("push2", 2, 64'h2008);

        ras.BPReturnF = 1;
        step();
        check_state("pop", 1, 64'h1004);

        ras.BPReturnF = 1; ras.StallD = 1;
        step();
        check_state("pop_stalld", 1, 64'h1004);
        ras.BPReturnF = 1; ras.FlushD = 1;
        step();
        check_state("pop_flushd", 1, 64'h1004);

        // asynchronous reset between clock edges
        #2;
        reset_n = 0;
        #1;
        check_state("async_rst", 0, 64'h0);
        @(posedge clk);
        #1;
        reset_n = 1;

        ras.BPReturnF = 1;
        step();
        check_state("pop_wrap", 15, 64'h0);

        do_reset();
        for (int i = 0; i < 17; i++) push(64'h100 + 64'(i));
        check_state("push_wrap", 1, 64'h110);
        chk("mem1", dut.mem[1], 64'h110);
        chk("mem0", dut.mem[0], 64'h10f);
        chk("mem2", dut.mem[2], 64'h101);

        ras.BPReturnWrongD = 1;
        step();
        chk("rep_inc", 64'(dut.ptr), 64'd2);
        ras.BPReturnWrongD = 1; ras.ReturnD = 1;
        step();
        chk("rep_dec", 64'(dut.ptr), 64'd1);
        ras.FlushM = 1; ras.ReturnE = 1;
        step();
        chk("rep_flushm", 64'(dut.ptr), 64'd2);
        ras.FlushE = 1; ras.ReturnD = 1;
        step();
        chk("rep_flushe", 64'(dut.ptr), 64'd3);
        ras.BPReturnWrongD = 1; ras.StallE = 1;
        step();
        chk("rep_stalle", 64'(dut.ptr), 64'd3);
        ras.FlushE = 1; ras.StallE = 1; ras.ReturnD = 1;
        step();
        chk("flushe_stalle", 64'(dut.ptr), 64'd3);

        ras.CallE = 1; ras.PCLinkE = 64'hABC; ras.BPReturnF = 1;
        step();
        check_state("push_pop", 2, 64'hABC);
        chk("mem2_pp", dut.mem[2], 64'hABC);

        push(64'hDEAD);
        check_state("push3", 3, 64'hDEAD);
        ras.BPReturnF = 1; ras.FlushM = 1; ras.ReturnE = 1;
        step();
        check_state("pop_flushret", 4, 64'h103);

        ras.CallE = 1; ras.StallM = 1; ras.PCLinkE = 64'h5555;
        step();
        check_state("push_stallm", 4, 64'h103);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
